// File: rtl/vga_sync.sv
// vga_sync: free-running VGA timing generator.
// Divides clk down to a pixel rate, steps the horizontal/vertical pixel
// counters, and decodes registered hsync/vsync/video_on plus frame-level
// strobes so that every output lines up with the counters it describes.
module vga_sync #(
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter int   CLK_DIV   = 2,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pixel_tick,
    output logic [9:0] h_counter,
    output logic [9:0] v_counter,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start,
    output logic       vblank_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]       V_VIS_10  = 10'(V_VISIBLE);
    localparam logic             SYNC_IDLE = ~SYNC_POL;

    // Reject parameter sets whose totals do not fit the 10-bit counters.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
        $error("vga_sync: H_TOTAL/V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_sync: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div_cnt_d, div_cnt_q;
    logic             pixel_tick_d, pixel_tick_q;
    logic [9:0]       h_counter_d, h_counter_q;
    logic [9:0]       v_counter_d, v_counter_q;
    logic             hsync_d, hsync_q;
    logic             vsync_d, vsync_q;
    logic             video_on_d, video_on_q;
    logic             frame_start_d, frame_start_q;
    logic             vblank_start_d, vblank_start_q;
    logic [7:0]       frame_count_d, frame_count_q;
    logic             step_en;
    logic             at_origin;

    // Next-state: divider, counter step, and decode of the next counter values.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        div_cnt_d      = div_cnt_q;
        h_counter_d    = h_counter_q;
        v_counter_d    = v_counter_q;
        frame_count_d  = frame_count_q;

        // The counters step on the same edge that raises pixel_tick.
        step_en      = (div_cnt_q == DIV_LAST);
        pixel_tick_d = step_en;

        if (step_en) begin
            div_cnt_d = '0;
            if (h_counter_q == H_LAST) begin
                h_counter_d = '0;
                v_counter_d = (v_counter_q == V_LAST) ? 10'd0 : v_counter_q + 10'd1;
            end else begin
                h_counter_d = h_counter_q + 10'd1;
            end
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end

        // Decode from the next counter values so registered outputs match the counters.
        hsync_d = (({1'b0, h_counter_d} >= 11'(HS_START)) &&
                   ({1'b0, h_counter_d} <  11'(HS_END))) ? SYNC_POL : SYNC_IDLE;
        vsync_d = (({1'b0, v_counter_d} >= 11'(VS_START)) &&
                   ({1'b0, v_counter_d} <  11'(VS_END))) ? SYNC_POL : SYNC_IDLE;
        video_on_d = ({1'b0, h_counter_d} < 11'(H_VISIBLE)) &&
                     ({1'b0, v_counter_d} < 11'(V_VISIBLE));

        // Strobes fire only on the stepping edge that lands on their position.
        at_origin      = (h_counter_d == 10'd0);
        frame_start_d  = step_en && at_origin && (v_counter_d == 10'd0);
        vblank_start_d = step_en && at_origin && (v_counter_d == V_VIS_10);
        if (frame_start_d) begin
            frame_count_d = frame_count_q + 8'd1;
        end
    end

    // State registers with synchronous active-low reset to the pre-frame position.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
        if (!rst_n) begin
            div_cnt_q      <= '0;
            pixel_tick_q   <= 1'b0;
            h_counter_q    <= H_LAST;
            v_counter_q    <= V_LAST;
            hsync_q        <= SYNC_IDLE;
            vsync_q        <= SYNC_IDLE;
            video_on_q     <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
            frame_count_q  <= 8'd0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            pixel_tick_q   <= pixel_tick_d;
            h_counter_q    <= h_counter_d;
            v_counter_q    <= v_counter_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            video_on_q     <= video_on_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
            frame_count_q  <= frame_count_d;
        end
    end

    assign pixel_tick   = pixel_tick_q;
    assign h_counter    = h_counter_q;
    assign v_counter    = v_counter_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign video_on     = video_on_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: directed checks of vga_sync.
// u_a: default 640x480 timing, CLK_DIV=2, active-low sync.
// u_b: default timing with CLK_DIV=1.
// u_c: tiny 8x6 raster, CLK_DIV=2, active-high sync, for frame-level behaviour.
module tb_vga_sync;

    logic clk;
    logic rst_a_n, rst_b_n, rst_c_n;

    logic       pt_a, hs_a, vs_a, vid_a, fs_a, vb_a;
    logic [9:0] h_a, v_a;
    logic [7:0] fc_a;
    logic       pt_b, hs_b, vs_b, vid_b, fs_b, vb_b;
    logic [9:0] h_b, v_b;
    logic [7:0] fc_b;
    logic       pt_c, hs_c, vs_c, vid_c, fs_c, vb_c;
    logic [9:0] h_c, v_c;
    logic [7:0] fc_c;

    int total = 0;
    int bad   = 0;

    vga_sync u_a (
        .clk(clk), .rst_n(rst_a_n), .pixel_tick(pt_a), .h_counter(h_a), .v_counter(v_a),
        .hsync(hs_a), .vsync(vs_a), .video_on(vid_a), .frame_start(fs_a),
        .vblank_start(vb_a), .frame_count(fc_a)
    );

    vga_sync #(.CLK_DIV(1)) u_b (
        .clk(clk), .rst_n(rst_b_n), .pixel_tick(pt_b), .h_counter(h_b), .v_counter(v_b),
        .hsync(hs_b), .vsync(vs_b), .video_on(vid_b), .frame_start(fs_b),
        .vblank_start(vb_b), .frame_count(fc_b)
    );

    vga_sync #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(2), .SYNC_POL(1'b1)
    ) u_c (
        .clk(clk), .rst_n(rst_c_n), .pixel_tick(pt_c), .h_counter(h_c), .v_counter(v_c),
        .hsync(hs_c), .vsync(vs_c), .video_on(vid_c), .frame_start(fs_c),
        .vblank_start(vb_c), .frame_count(fc_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clk and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        int lows, hs_first, hs_last, fall_h, cnt_pt, cnt_fs;
        int vs_cnt, hs_cnt, fs_cnt, fs_idx, vb_cnt, vb_idx, vb_h, vb_v;
        logic prev_vid;
        logic [9:0] ph, pv;
        bit found;

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        rst_c_n = 1'b0;
        repeat (4) tick();

        // Reset state
        check("a_rst_h", h_a, 799);
        check("a_rst_v", v_a, 524);
        check("a_rst_hsync", hs_a, 1);
        check("a_rst_vsync", vs_a, 1);
        check("a_rst_video", vid_a, 0);
        check("a_rst_tick", pt_a, 0);
        check("a_rst_fs", fs_a, 0);
        check("a_rst_vb", vb_a, 0);
        check("a_rst_fc", fc_a, 0);
        check("c_rst_h", h_c, 7);
        check("c_rst_v", v_c, 5);
        check("c_rst_hsync", hs_c, 0);
        check("c_rst_vsync", vs_c, 0);

        // Release: first tick lands on the 2nd clk
        rst_a_n = 1'b1;
        tick();
        check("a_rel1_h", h_a, 799);
        check("a_rel1_tick", pt_a, 0);
        check("a_rel1_fs", fs_a, 0);
        tick();
        check("a_rel2_h", h_a, 0);
        check("a_rel2_v", v_a, 0);
        check("a_rel2_tick", pt_a, 1);
        check("a_rel2_video", vid_a, 1);
        check("a_rel2_fs", fs_a, 1);
        check("a_rel2_fc", fc_a, 1);
        check("a_rel2_hsync", hs_a, 1);
        tick();
        check("a_rel3_tick", pt_a, 0);
        check("a_rel3_fs", fs_a, 0);
        check("a_rel3_h", h_a, 0);

        // One full line of clks: hsync window, video_on fall, period
        lows = 0; hs_first = -1; hs_last = -1; fall_h = -1;
        prev_vid = vid_a;
        for (int i = 0; i < 1600; i++) begin
            tick();
            if (!hs_a) begin
                if (lows == 0) hs_first = int'(h_a);
                hs_last = int'(h_a);
                lows++;
            end
            if (prev_vid && !vid_a) fall_h = int'(h_a);
            prev_vid = vid_a;
        end
        check("a_hsync_low_clks", lows, 192);
        check("a_hsync_first_h", hs_first, 656);
        check("a_hsync_last_h", hs_last, 751);
        check("a_video_fall_h", fall_h, 640);
        check("a_line_h", h_a, 0);
        check("a_line_v", v_a, 1);

        // Mid-line reset at h=300
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            tick();
            if (h_a == 10'd300) found = 1'b1;
        end
        check("a_wait_h300", found, 1);
        rst_a_n = 1'b0;
        tick();
        check("a_mid_rst_h", h_a, 799);
        check("a_mid_rst_v", v_a, 524);
        check("a_mid_rst_hsync", hs_a, 1);
        check("a_mid_rst_vsync", vs_a, 1);
        check("a_mid_rst_video", vid_a, 0);
        check("a_mid_rst_fc", fc_a, 0);
        check("a_mid_rst_tick", pt_a, 0);

        // CLK_DIV=1: tick held high, 800-clk line
        rst_b_n = 1'b1;
        tick();
        check("b_rel_h", h_b, 0);
        check("b_rel_v", v_b, 0);
        check("b_rel_tick", pt_b, 1);
        check("b_rel_fs", fs_b, 1);
        check("b_rel_fc", fc_b, 1);
        check("b_rel_video", vid_b, 1);
        cnt_pt = 0; cnt_fs = 0;
        for (int i = 0; i < 800; i++) begin
            tick();
            cnt_pt += int'(pt_b);
            cnt_fs += int'(fs_b);
        end
        check("b_tick_clks", cnt_pt, 800);
        check("b_fs_in_line", cnt_fs, 0);
        check("b_line_h", h_b, 0);
        check("b_line_v", v_b, 1);

        // Small raster, active-high sync
        rst_c_n = 1'b1;
        tick();
        tick();
        check("c_rel_h", h_c, 0);
        check("c_rel_v", v_c, 0);
        check("c_rel_fs", fs_c, 1);
        check("c_rel_fc", fc_c, 1);
        check("c_rel_video", vid_c, 1);
        check("c_rel_hsync", hs_c, 0);

        // One frame (8*6*2 = 96 clks)
        vs_cnt = 0; hs_cnt = 0; fs_cnt = 0; fs_idx = -1;
        vb_cnt = 0; vb_idx = -1; vb_h = -1; vb_v = -1;
        for (int i = 1; i <= 96; i++) begin
            tick();
            if (vs_c) vs_cnt++;
            if (hs_c) hs_cnt++;
            if (fs_c) begin fs_cnt++; fs_idx = i; end
            if (vb_c) begin vb_cnt++; vb_idx = i; vb_h = int'(h_c); vb_v = int'(v_c); end
        end
        check("c_vsync_clks", vs_cnt, 16);
        check("c_hsync_clks", hs_cnt, 24);
        check("c_fs_count", fs_cnt, 1);
        check("c_fs_period", fs_idx, 96);
        check("c_vb_count", vb_cnt, 1);
        check("c_vb_idx", vb_idx, 48);
        check("c_vb_h", vb_h, 0);
        check("c_vb_v", vb_v, 3);
        check("c_fc_after_frame", fc_c, 2);

        // Run until frame_count wraps 255 -> 0
        found = 1'b0; fs_cnt = 0; ph = '0; pv = '0;
        for (int i = 0; i < 25000 && !found; i++) begin
            ph = h_c;
            pv = v_c;
            tick();
            if (fs_c) begin
                fs_cnt++;
                if (fc_c == 8'd0) found = 1'b1;
            end
        end
        check("c_wrap_found", found, 1);
        check("c_wrap_frames", fs_cnt, 254);
        check("c_wrap_prev_h", ph, 7);
        check("c_wrap_prev_v", pv, 5);
        check("c_wrap_h", h_c, 0);
        check("c_wrap_v", v_c, 0);
        check("c_wrap_vb", vb_c, 0);

        // Mid-frame reset inside both sync pulses
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (h_c == 10'd5 && v_c == 10'd4) found = 1'b1;
        end
        check("c_wait_5_4", found, 1);
        check("c_sync_hsync", hs_c, 1);
        check("c_sync_vsync", vs_c, 1);
        rst_c_n = 1'b0;
        tick();
        check("c_mid_rst_h", h_c, 7);
        check("c_mid_rst_v", v_c, 5);
        check("c_mid_rst_hsync", hs_c, 0);
        check("c_mid_rst_vsync", vs_c, 0);
        check("c_mid_rst_fc", fc_c, 0);
        check("c_mid_rst_fs", fs_c, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_sync.md
# vga_sync

Timing generator for the VGA output path. It divides the system clock down to a pixel rate and produces the horizontal and vertical pixel counters that the pixel-drawing logic consumes. It also produces registered hsync/vsync/video_on outputs and frame-level strobes, so game logic can update object positions (Ax/Ay, Bx/By) during blanking. It sits between the board clock and the display renderer, and drives the VGA connector sync pins directly.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (≥1)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock; every register updates on its rising edge
- rst_n  in  1  synchronous active-low reset
- pixel_tick  out  1  one-clk strobe, once every CLK_DIV clks; counters advance on it
- h_counter  out  10  current pixel column, 0..H_TOTAL-1
- v_counter  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per SYNC_POL
- vsync  out  1  vertical sync, polarity per SYNC_POL
- video_on  out  1  high when (h_counter, v_counter) is in the visible area
- frame_start  out  1  one-clk pulse when the counters wrap to (0,0)
- vblank_start  out  1  one-clk pulse when the counters enter (0, V_VISIBLE)
- frame_count  out  8  frames started since reset, wraps at 255

## Operation
- Derived values: H_TOTAL = sum of the four H params (800); V_TOTAL = sum of the four V params (525).
- Legal parameter sets: both totals are ≤1024, so they fit the 10-bit counters. Illegal sets are rejected at elaboration.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pixel_tick is registered and high in the clk cycle after div_cnt==CLK_DIV-1.
  - With CLK_DIV=1, pixel_tick is held high.
- Horizontal counter:
  - On each pixel_tick, h_counter increments.
  - When h_counter==H_TOTAL-1, it wraps to 0 and v_counter advances.
- Vertical counter:
  - v_counter increments on each h wrap.
  - When v_counter==V_TOTAL-1, it wraps to 0.
- Sync and video decode (from counter values):
  - hsync is active iff H_VISIBLE+H_FRONT ≤ h < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vsync is active iff V_VISIBLE+V_FRONT ≤ v < V_VISIBLE+V_FRONT+V_SYNC (490..491).
  - video_on = (h < H_VISIBLE) && (v < V_VISIBLE).
  - Inactive sync level is !SYNC_POL.
- Registering: hsync, vsync and video_on are registered from the *next* counter values. They therefore always match the h_counter/v_counter presented in the same cycle, with no skew.
- frame_start:
  - Pulses for exactly one clk on the edge where the counters become (0,0).
  - frame_count increments on that same edge; 255 wraps to 0.
- vblank_start: pulses for exactly one clk on the edge where the counters become (0, V_VISIBLE).
- State: no handshake. The block free-runs and has no stall input.

## Timing
- Reset values:
  - h_counter=H_TOTAL-1 (799), v_counter=V_TOTAL-1 (524).
  - hsync=vsync=!SYNC_POL (1), video_on=0.
  - pixel_tick=0, frame_start=0, vblank_start=0, frame_count=0, div_cnt=0.
- First frame: the first pixel_tick after reset release moves the counters to (0,0). On that tick video_on=1, frame_start=1 and frame_count=1.
- Latency: all outputs update on the same clk edge as the counter step. Between steps, outputs are held for CLK_DIV clks.
- Line period is H_TOTAL·CLK_DIV clks; frame period is H_TOTAL·V_TOTAL·CLK_DIV clks (840000 at defaults).
- Reset mid-frame: on the first edge with rst_n=0, all outputs return to their reset values. Strobes in flight are dropped.
- Simultaneous h-wrap and v-wrap (799,524 → 0,0): both happen on one edge. frame_start fires; vblank_start does not.

## Test plan
- Reset release: rst_n low 4 clks, then high → outputs hold reset values until the first pixel_tick (2nd clk after release); the counters then read (0,0), with video_on=1 and frame_start=1 for one clk.
- Line timing with CLK_DIV=2 → hsync low exactly for h=656..751, i.e. 192 clks per line; line period 1600 clks; video_on falls as h becomes 640.
- Frame timing → vsync low for v=490..491; vblank_start pulses once per frame at (0,480); frame_start period is 840000 clks.
- Wrap: run 256 frames → frame_count goes 255→0; at (799,524)→(0,0), frame_start=1 and vblank_start=0.
- Reset mid-frame: assert rst_n=0 at (300,200) → on the next edge the counters read (799,524), hsync=vsync=1, frame_count=0.
- CLK_DIV=1 → pixel_tick is constantly high after reset release; line period is 800 clks.
